// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU control unit and word-addressed data memory.
// Sub-word stores use read-modify-write; loads return the lane-shifted word plus the extend/cut controls.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_ec_cs,
  output logic        o_sign_ec,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_op;
  logic [31:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_rdata;
  logic [2:0]    r_ec_cs;
  logic          r_sign_ec;
  logic          r_addr_err;
  logic          r_bus_err;
  logic [CW-1:0] r_cnt;

  logic          w_misalign;
  logic          w_timeout;
  logic          w_is_store;
  logic [2:0]    w_ec_cs;
  logic          w_sign_ec;
  logic [31:0]   w_rdata_sh;
  logic [31:0]   w_merged;

  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_is_store = (r_op == OP_SH) || (r_op == OP_SB);

  always_comb begin
    w_misalign = 1'b0;
    w_ec_cs    = 3'b000;
    w_sign_ec  = 1'b0;
    unique case (i_op)
      OP_LW:  w_misalign = |i_addr[1:0];
      OP_SW:  w_misalign = |i_addr[1:0];
      OP_LH:  begin w_misalign = i_addr[0]; w_ec_cs = 3'b001; w_sign_ec = 1'b1; end
      OP_LHU: begin w_misalign = i_addr[0]; w_ec_cs = 3'b001; end
      OP_SH:  w_misalign = i_addr[0];
      OP_LB:  begin w_ec_cs = 3'b010; w_sign_ec = 1'b1; end
      OP_LBU: w_ec_cs = 3'b010;
      default: ;
    endcase
  end

  // Load lane alignment and read-modify-write merge, both based on the latched address.
  always_comb begin
    w_rdata_sh = i_mem_rdata;
    w_merged   = i_mem_rdata;
    unique case (r_op)
      OP_LH, OP_LHU: w_rdata_sh = i_mem_rdata >> {r_addr[1], 4'b0000};
      OP_LB, OP_LBU: w_rdata_sh = i_mem_rdata >> {r_addr[1:0], 3'b000};
      OP_SH:         w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
      OP_SB:         w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_misalign)        w_next = S_DONE;
          else if (i_op == OP_SW) w_next = S_WR;
          else                   w_next = S_RD;
        end
      end
      S_RD: begin
        if (i_mem_ready)    w_next = w_is_store ? S_WR : S_DONE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WR: begin
        if (i_mem_ready || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 16'h0;
      r_mem_wdata <= 32'h0;
      r_rdata     <= 32'h0;
      r_ec_cs     <= 3'b000;
      r_sign_ec   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op       <= i_op;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata[15:0];
            r_ec_cs    <= w_ec_cs;
            r_sign_ec  <= w_sign_ec;
            r_addr_err <= w_misalign;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
            if (i_op == OP_SW) r_mem_wdata <= i_wdata;
          end
        end
        S_RD: begin
          if (i_mem_ready) begin
            r_cnt <= '0;
            if (w_is_store) r_mem_wdata <= w_merged;
            else            r_rdata     <= w_rdata_sh;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR: begin
          if (!i_mem_ready) begin
            if (w_timeout) r_bus_err <= 1'b1;
            else           r_cnt     <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_mem_rd    = (r_state == S_RD);
  assign o_mem_wr    = (r_state == S_WR);
  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_wdata = r_mem_wdata;
  assign o_rdata     = r_rdata;
  assign o_ec_cs     = r_ec_cs;
  assign o_sign_ec   = r_sign_ec;
  assign o_addr_err  = r_addr_err;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a behavioural memory with programmable wait states
// answers the DUT, expectations are queued at start and compared when done pulses.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_busy, o_done, o_sign_ec, o_addr_err, o_bus_err, o_mem_rd, o_mem_wr;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [2:0]  o_ec_cs;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        i_mem_ready = 1'b0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_rdata(o_rdata), .o_ec_cs(o_ec_cs), .o_sign_ec(o_sign_ec),
    .o_addr_err(o_addr_err), .o_bus_err(o_bus_err), .o_mem_addr(o_mem_addr),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        checkRdata;
    logic [2:0]  ec;
    logic        sign;
    logic        aerr;
    logic        berr;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] wword;
    logic [31:0] maddr;
  } expT;

  expT expQ[$];
  int testCount = 0;
  int failCount = 0;

  // Behavioural memory state, sampled and driven on the falling edge.
  logic [31:0] memWord = 32'h0;
  int          memWaits = 0;
  int          memCnt = 0;
  int          rdCycles = 0;
  int          wrCycles = 0;
  int          wrCount = 0;
  int          overlap = 0;
  logic [31:0] wrWord = 32'h0;
  logic [31:0] seenAddr = 32'h0;
  logic        addrSeen = 1'b0;

  always @(negedge i_clk) begin
    if (o_mem_rd || o_mem_wr) begin
      if (i_mem_ready) memCnt = 0;
      if (memCnt == memWaits) i_mem_ready = 1'b1;
      else begin
        i_mem_ready = 1'b0;
        memCnt++;
      end
      if (o_mem_rd) rdCycles++;
      if (o_mem_wr) wrCycles++;
      if (o_mem_rd && o_mem_wr) overlap++;
      if (!addrSeen) begin
        seenAddr = o_mem_addr;
        addrSeen = 1'b1;
      end
      if (o_mem_wr && i_mem_ready) begin
        wrWord = o_mem_wdata;
        wrCount++;
      end
    end else begin
      i_mem_ready = 1'b0;
      memCnt = 0;
    end
    i_mem_rdata = memWord;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic expT modelOf(input string tag, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word, input int waits);
    expT e;
    logic [7:0] b[4];
    int lane;
    logic mis;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    e.tag = tag; e.rdata = 32'h0; e.checkRdata = 1'b0; e.ec = 3'b000; e.sign = 1'b0;
    e.aerr = 1'b0; e.berr = 1'b0; e.reads = 0; e.writes = 0; e.wword = 32'h0;
    e.maddr = {addr[31:2], 2'b00};
    lane = 0;
    mis = 1'b0;
    case (op)
      3'd0, 3'd5: mis = (addr[1:0] != 2'b00);
      3'd1, 3'd2, 3'd6: mis = addr[0];
      default: mis = 1'b0;
    endcase
    if (op == 3'd1 || op == 3'd2) begin e.ec = 3'b001; lane = addr[1] ? 2 : 0; end
    if (op == 3'd3 || op == 3'd4) begin e.ec = 3'b010; lane = int'(addr[1:0]); end
    e.sign = (op == 3'd1) || (op == 3'd3);
    if (mis) begin
      e.aerr = 1'b1; e.lat = 1;
    end else if (waits >= TIMEOUT) begin
      e.berr = 1'b1; e.lat = TIMEOUT + 1;
      if (op == 3'd5) e.writes = TIMEOUT; else e.reads = TIMEOUT;
    end else if (op <= 3'd4) begin
      e.reads = waits + 1; e.lat = waits + 2; e.checkRdata = 1'b1;
      for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = (lane + i < 4) ? b[lane + i] : 8'h00;
    end else if (op == 3'd5) begin
      e.writes = waits + 1; e.lat = waits + 2; e.wword = wdata;
    end else begin
      if (op == 3'd7) b[addr[1:0]] = wdata[7:0];
      else begin
        b[{addr[1], 1'b0}] = wdata[7:0];
        b[{addr[1], 1'b1}] = wdata[15:8];
      end
      e.reads = waits + 1; e.writes = waits + 1; e.lat = 2 * waits + 3;
      e.wword = {b[3], b[2], b[1], b[0]};
    end
    return e;
  endfunction

  // Drive one request, wait (bounded) for done, then score it against the queued expectation.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] word, input int waits,
                               input int midStart);
    expT e;
    int cyc;
    logic gotDone;
    memWord = word; memWaits = waits;
    rdCycles = 0; wrCycles = 0; wrCount = 0; overlap = 0; addrSeen = 1'b0;
    expQ.push_back(modelOf(tag, op, addr, wdata, word, waits));
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_addr = addr; i_wdata = wdata;
    cyc = 0; gotDone = 1'b0;
    while (!gotDone && cyc < 100) begin
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
      if (o_done) gotDone = 1'b1;
      else if (cyc == midStart) begin
        i_start = 1'b1; i_op = 3'b101; i_addr = 32'h0000_0400;
      end
    end
    e = expQ.pop_front();
    checkOutput({e.tag, ".doneSeen"}, 64'(gotDone), 64'(1));
    checkOutput({e.tag, ".latency"}, 64'(cyc), 64'(e.lat));
    checkOutput({e.tag, ".ecCs"}, 64'(o_ec_cs), 64'(e.ec));
    checkOutput({e.tag, ".signEc"}, 64'(o_sign_ec), 64'(e.sign));
    checkOutput({e.tag, ".addrErr"}, 64'(o_addr_err), 64'(e.aerr));
    checkOutput({e.tag, ".busErr"}, 64'(o_bus_err), 64'(e.berr));
    checkOutput({e.tag, ".rdCycles"}, 64'(rdCycles), 64'(e.reads));
    checkOutput({e.tag, ".wrCycles"}, 64'(wrCycles), 64'(e.writes));
    checkOutput({e.tag, ".overlap"}, 64'(overlap), 64'(0));
    if (e.checkRdata) checkOutput({e.tag, ".rdata"}, 64'(o_rdata), 64'(e.rdata));
    if (e.writes > 0 && !e.berr) checkOutput({e.tag, ".wrWord"}, 64'(wrWord), 64'(e.wword));
    if (e.reads + e.writes > 0) checkOutput({e.tag, ".memAddr"}, 64'(seenAddr), 64'(e.maddr));
    @(negedge i_clk);
    checkOutput({e.tag, ".donePulse"}, 64'({o_done, o_busy}), 64'(0));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".rdata"}, 64'(o_rdata), 64'(0));
    checkOutput({tag, ".memAddr"}, 64'(o_mem_addr), 64'(0));
    checkOutput({tag, ".memWdata"}, 64'(o_mem_wdata), 64'(0));
    checkOutput({tag, ".ctrl"}, 64'({o_busy, o_done, o_ec_cs, o_sign_ec, o_addr_err,
                                      o_bus_err, o_mem_rd, o_mem_wr}), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    checkResetState("reset");
    i_rst_n = 1'b1;

    applyStimulus("lbNeg",     3'b011, 32'h0000_0103, 32'h0,         32'h80AB_CD12, 0, 0);
    applyStimulus("lhuWait",   3'b010, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 3, 0);
    applyStimulus("sbMerge",   3'b111, 32'h0000_0201, 32'h0000_00AA, 32'h1122_3344, 0, 0);
    applyStimulus("swMisal",   3'b101, 32'h0000_0202, 32'h1234_5678, 32'h0,         0, 0);
    applyStimulus("swAligned", 3'b101, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         1, 0);
    applyStimulus("lwTimeout", 3'b000, 32'h0000_0300, 32'h0,         32'h0,         1000, 5);
    applyStimulus("lhSigned",  3'b001, 32'h0000_0012, 32'h0,         32'h8001_7FFE, 0, 0);
    applyStimulus("lbuLane1",  3'b100, 32'h0000_0021, 32'h0,         32'hA1B2_C3D4, 2, 0);
    applyStimulus("shUpper",   3'b110, 32'h0000_0206, 32'hFFFF_5A5A, 32'hDEAD_BEEF, 1, 0);
    applyStimulus("lhMisal",   3'b001, 32'h0000_0101, 32'h0,         32'h0,         0, 0);
    applyStimulus("lwWait",    3'b000, 32'h0000_0040, 32'h0,         32'h0F1E_2D3C, 2, 0);

    // Abort a store stuck in its write wait, then confirm a clean restart.
    memWaits = 1000;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'b101; i_addr = 32'h0000_0500; i_wdata = 32'h5555_AAAA;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("rstMid.inWr", 64'(o_mem_wr), 64'(1));
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkResetState("rstMid");
    i_rst_n = 1'b1;
    applyStimulus("lwAfterRst", 3'b000, 32'h0000_0080, 32'h0, 32'h7654_3210, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store sequencer between the CPU control unit and the word-addressed data memory. Accepts one lw/lh/lhu/lb/lbu/sw/sh/sb request at a time and issues word-aligned memory reads/writes with a ready handshake. Sub-word stores use read-modify-write. For loads it returns the lane-shifted word plus the extend/cut select code and sign flag for the downstream extend/cut unit.

## Interface
- TIMEOUT, 16: maximum cycles to wait for mem_ready per access before aborting with bus_err (≥2).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte or halfword is used for sb/sh.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load word shifted so the selected lane sits at bit 0.
- ec_cs  out  3  extend/cut select: 000 word pass, 001 halfword, 010 byte.
- sign_ec  out  1  sign-extend enable for the extend/cut unit.
- addr_err  out  1  misaligned request flag.
- bus_err  out  1  memory timeout flag.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_rd  out  1  read request, held until acknowledged.
- mem_wr  out  1  write request, held until acknowledged.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  acknowledge for the current mem_rd/mem_wr.

## Operation
- States: IDLE, RD, WR, DONE.
- In IDLE with start=1, the block latches op, addr and wdata, then:
  - Misaligned request: lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1. Go to DONE with addr_err=1 and no memory access.
  - lw/lh/lhu/lb/lbu/sh/sb: go to RD.
  - sw: go to WR with mem_wdata=wdata.
- RD:
  - mem_rd=1.
  - On mem_ready=1, capture mem_rdata.
  - Loads then go to DONE.
  - sh/sb then go to WR. The merged word replaces lane addr[1:0] (byte) or addr[1] (halfword) with wdata[7:0]/wdata[15:0]; other bytes are kept.
- WR: mem_wr=1; on mem_ready=1 go to DONE.
- Wait counter: reset on entry to RD/WR, increments each cycle without mem_ready. When it reaches TIMEOUT-1 with mem_ready still low, deassert the request, set bus_err=1 and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Byte order is little-endian: lane 0 is bits[7:0].
  - rdata = mem_rdata >> (8·addr[1:0]) for bytes, >> (16·addr[1]) for halfwords, and unshifted for lw.
  - Upper bits of rdata are don't-care to the extend/cut unit but are driven as the shifted value, zero-filled.
- ec_cs/sign_ec by op:
  - lw: 000/0
  - lh: 001/1
  - lhu: 001/0
  - lb: 010/1
  - lbu: 010/0
  - stores: 000/0
- rdata, ec_cs, sign_ec, addr_err and bus_err are valid from DONE and held until the next accepted start, which clears both error flags.
- start while busy=1 is ignored; there is no queueing.
- mem_rd and mem_wr are never high in the same cycle.

## Timing
- Reset (rst_n=0 at a clock edge) forces IDLE and drives every output to 0. This includes rdata, mem_addr and mem_wdata. An in-flight access is dropped.
- mem_addr/mem_wdata are stable for the entire time mem_rd/mem_wr is high.
- Loads, zero-wait memory (ready high in the first RD cycle):
  - start at cycle 0, RD at cycle 1, DONE at cycle 2.
  - Latency is 2 cycles start→done.
- sw, zero-wait memory: WR at cycle 1, done at cycle 2.
- sb/sh: RD at cycle 1, WR at cycle 2, done at cycle 3.
- Each mem_ready wait cycle adds 1 cycle.
- Misaligned request: done at cycle 1, with mem_rd/mem_wr never asserted.
- Timeout: with mem_ready stuck at 0, the request is high for exactly TIMEOUT cycles. bus_err and done are asserted in the following cycle.
- mem_ready while neither request is high is ignored.

## Test plan
- lb at addr 0x103, memory word 0x80AB_CD12, zero-wait:
  - rdata[7:0]=0x80, ec_cs=010, sign_ec=1.
  - done at cycle 2; mem_addr=0x100.
- lhu at addr 0x102, word 0xBEEF_1234, 3 wait cycles:
  - rdata[15:0]=0xBEEF, ec_cs=001, sign_ec=0.
  - done at cycle 5.
- sb at addr 0x201, wdata 0x0000_00AA, memory word 0x1122_3344:
  - one read, then a write of 0x1122_AA44.
  - done at cycle 3; mem_rd/mem_wr never overlap.
- sw at addr 0x202:
  - addr_err=1, done at cycle 1, no memory strobe.
  - A subsequent aligned sw clears addr_err.
- lw with mem_ready held 0, TIMEOUT=16:
  - mem_rd high for 16 cycles, then bus_err=1 with done.
  - A start pulse mid-wait is ignored.
- rst_n=0 during a WR wait:
  - next cycle all outputs are 0 and state is IDLE.
  - A following lw completes normally.
